// File: rtl/qspi_mem_ctrl.sv
// qspi_mem_ctrl: turns single-beat CPU memory requests into quad-SPI transfers
// (command, 24-bit address, dummy, data nibbles) on a bus shared by program
// flash, RAM A and an optional RAM B.
// Optional feature macro: QSPI_RAM_B_EN adds the RAM B decode and chip select.
module qspi_mem_ctrl #(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned DUMMY_NIBBLES  = 4,
    parameter logic [7:0]  CMD_READ       = 8'h0B,
    parameter logic [7:0]  CMD_WRITE      = 8'h02
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    input  logic [3:0]                qspi_data_in,
    output logic [3:0]                qspi_data_out,
    output logic [3:0]                qspi_data_oe,
    output logic                      qspi_clk,
    output logic                      qspi_flash_select,
    output logic                      qspi_ram_a_select,
    output logic                      qspi_ram_b_select
);

    localparam int unsigned DW        = DATA_BUS_WIDTH;
    localparam int unsigned AW        = ADDRESS_WIDTH;
    localparam int unsigned NIB       = DW / 4;
    localparam int unsigned MAX_A     = (NIB > 6) ? NIB : 6;
    localparam int unsigned MAX_FIELD = (DUMMY_NIBBLES > MAX_A) ? DUMMY_NIBBLES : MAX_A;
    localparam int unsigned CNT_W     = $clog2(MAX_FIELD);
    localparam int unsigned TX_W      = 32 + DW;

    localparam logic [1:0] DEV_FLASH = 2'd0;
    localparam logic [1:0] DEV_RAM_A = 2'd1;
`ifdef QSPI_RAM_B_EN
    localparam logic [1:0] DEV_RAM_B = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_DONE
    } state_e;

    state_e             state_q, state_d, field_next;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, field_last;
    logic [TX_W-1:0]    tx_q, tx_d;
    logic [DW-1:0]      rx_q, rx_d, rx_shift;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               write_q, write_d;
    logic [1:0]         dev_q, dev_d, dec_dev;
    logic [23:0]        dec_addr;
    logic               rej_q, rej_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               sel_f_q, sel_f_d;
    logic               sel_a_q, sel_a_d;
    logic               qclk_q, qclk_d;
    logic [3:0]         dout_q, dout_d;
    logic [3:0]         oe_q, oe_d;
    logic               active, drive;
`ifdef QSPI_RAM_B_EN
    logic               sel_b_q, sel_b_d;
`endif

    // Device select and 24-bit device address from the CPU address
    always_comb begin
`ifdef QSPI_RAM_B_EN
        dec_dev  = !req_addr[AW-1] ? DEV_FLASH : (req_addr[AW-2] ? DEV_RAM_B : DEV_RAM_A);
        dec_addr = 24'(req_addr[AW-3:0]);
`else
        dec_dev  = req_addr[AW-1] ? DEV_RAM_A : DEV_FLASH;
        dec_addr = 24'(req_addr[AW-2:0]);
`endif
    end

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            dev_q       <= DEV_FLASH;
            rej_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            sel_f_q     <= 1'b1;
            sel_a_q     <= 1'b1;
`ifdef QSPI_RAM_B_EN
            sel_b_q     <= 1'b1;
`endif
            qclk_q      <= 1'b0;
            dout_q      <= 4'h0;
            oe_q        <= 4'h0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            dev_q       <= dev_d;
            rej_q       <= rej_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            sel_f_q     <= sel_f_d;
            sel_a_q     <= sel_a_d;
`ifdef QSPI_RAM_B_EN
            sel_b_q     <= sel_b_d;
`endif
            qclk_q      <= qclk_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    // Next state: request capture, nibble slot sequencing and read shifting
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        write_d  = write_q;
        dev_d    = dev_q;
        rej_d    = rej_q;
        rx_shift = DW'({rx_q, qspi_data_in});

        field_last = '0;
        field_next = S_DONE;
        case (state_q)
            S_CMD:   begin field_last = CNT_W'(1); field_next = S_ADDR; end
            S_ADDR:  begin
                field_last = CNT_W'(5);
                field_next = write_q ? S_WR : ((DUMMY_NIBBLES != 0) ? S_DUMMY : S_RD);
            end
            S_DUMMY: begin field_last = CNT_W'(DUMMY_NIBBLES - 1); field_next = S_RD; end
            S_RD:    begin field_last = CNT_W'(NIB - 1); field_next = S_DONE; end
            S_WR:    begin field_last = CNT_W'(NIB - 1); field_next = S_DONE; end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    dev_d   = dec_dev;
                    tx_d    = {(req_write ? CMD_WRITE : CMD_READ), dec_addr, req_wdata};
                    rx_d    = '0;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    rej_d   = req_write && (dec_dev == DEV_FLASH);
                    state_d = (req_write && (dec_dev == DEV_FLASH)) ? S_DONE : S_CMD;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (state_q == S_RD) begin
                        rx_d = rx_shift;
                    end else if (state_q != S_DUMMY) begin
                        tx_d = {tx_q[TX_W-5:0], 4'h0};
                    end
                    if (cnt_q == field_last) begin
                        cnt_d   = '0;
                        state_d = field_next;
                        if (state_q == S_RD) begin
                            rdata_d = rx_shift;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rej_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the pads change with the state
    always_comb begin
        active      = state_d inside {S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR};
        drive       = state_d inside {S_CMD, S_ADDR, S_WR};
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        rsp_err_d   = (state_d == S_DONE) && rej_d;
        sel_f_d     = !(active && (dev_d == DEV_FLASH));
        sel_a_d     = !(active && (dev_d == DEV_RAM_A));
`ifdef QSPI_RAM_B_EN
        sel_b_d     = !(active && (dev_d == DEV_RAM_B));
`endif
        qclk_d      = active && phase_d;
        oe_d        = drive ? 4'hF : 4'h0;
        dout_d      = drive ? tx_d[TX_W-1 -: 4] : 4'h0;
    end

    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_err           = rsp_err_q;
    assign rsp_rdata         = rdata_q;
    assign qspi_clk          = qclk_q;
    assign qspi_data_out     = dout_q;
    assign qspi_data_oe      = oe_q;
    assign qspi_flash_select = sel_f_q;
    assign qspi_ram_a_select = sel_a_q;
`ifdef QSPI_RAM_B_EN
    assign qspi_ram_b_select = sel_b_q;
`else
    assign qspi_ram_b_select = 1'b1;
`endif

endmodule
